// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI4 write arbiter: NUM_REQ masters share one slave write port,
// and each grant covers one whole AW -> W...WLAST -> B transaction.
module axi_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            m_awvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_REQ*ID_W-1:0]       m_awid,
    input  logic [NUM_REQ*8-1:0]          m_awlen,
    output logic [NUM_REQ-1:0]            m_awready,
    input  logic [NUM_REQ-1:0]            m_wvalid,
    input  logic [NUM_REQ*DATA_W-1:0]     m_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] m_wstrb,
    input  logic [NUM_REQ-1:0]            m_wlast,
    output logic [NUM_REQ-1:0]            m_wready,
    output logic [NUM_REQ-1:0]            m_bvalid,
    output logic [1:0]                    m_bresp,
    output logic [ID_W-1:0]               m_bid,
    input  logic [NUM_REQ-1:0]            m_bready,
    output logic                          s_awvalid,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic [ID_W-1:0]               s_awid,
    output logic [7:0]                    s_awlen,
    input  logic                          s_awready,
    output logic                          s_wvalid,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wlast,
    input  logic                          s_wready,
    input  logic                          s_bvalid,
    input  logic [1:0]                    s_bresp,
    input  logic [ID_W-1:0]               s_bid,
    output logic                          s_bready,
    output logic [NUM_REQ-1:0]            gnt
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]   gidx_reg, gidx_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;

    logic [ADDR_W-1:0]  awaddr_arr [NUM_REQ];
    logic [ID_W-1:0]    awid_arr   [NUM_REQ];
    logic [7:0]         awlen_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr  [NUM_REQ];
    logic [STRB_W-1:0]  wstrb_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign awaddr_arr[gi] = m_awaddr[gi*ADDR_W +: ADDR_W];
            assign awid_arr[gi]   = m_awid[gi*ID_W +: ID_W];
            assign awlen_arr[gi]  = m_awlen[gi*8 +: 8];
            assign wdata_arr[gi]  = m_wdata[gi*DATA_W +: DATA_W];
            assign wstrb_arr[gi]  = m_wstrb[gi*STRB_W +: STRB_W];
        end
    endgenerate

    logic sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    assign sel_awvalid = m_awvalid[gidx_reg];
    assign sel_wvalid  = m_wvalid[gidx_reg];
    assign sel_wlast   = m_wlast[gidx_reg];
    assign sel_bready  = m_bready[gidx_reg];

    // Payload always follows the granted master; the valids below qualify it.
    assign s_awaddr = awaddr_arr[gidx_reg];
    assign s_awid   = awid_arr[gidx_reg];
    assign s_awlen  = awlen_arr[gidx_reg];
    assign s_wdata  = wdata_arr[gidx_reg];
    assign s_wstrb  = wstrb_arr[gidx_reg];
    assign s_wlast  = sel_wlast;
    assign m_bresp  = s_bresp;
    assign m_bid    = s_bid;
    assign gnt      = gnt_reg;

    // Search starts one past the last completed master, so priority rotates.
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] cand;
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!win_found && m_awvalid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            gidx_reg  <= '0;
            ptr_reg   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            gidx_reg  <= gidx_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        gidx_next  = gidx_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next         = ADDR;
                    gnt_next           = '0;
                    gnt_next[win_idx]  = 1'b1;
                    gidx_next          = win_idx;
                end
            end
            ADDR: if (sel_awvalid && s_awready) state_next = DATA;
            DATA: if (sel_wvalid && s_wready && sel_wlast) state_next = RESP;
            RESP: begin
                if (s_bvalid && sel_bready) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    ptr_next   = gidx_reg;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        case (state_reg)
            ADDR: begin
                s_awvalid           = sel_awvalid;
                m_awready[gidx_reg] = s_awready;
            end
            DATA: begin
                s_wvalid           = sel_wvalid;
                m_wready[gidx_reg] = s_wready;
            end
            RESP: begin
                s_bready           = sel_bready;
                m_bvalid[gidx_reg] = s_bvalid;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Randomized bench for axi_wr_arbiter: master/slave stimulus driven from a
// transaction-level model that also predicts every handshake output each cycle.
module tb_axi_wr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_awvalid = '0, m_awready, m_wvalid = '0, m_wlast = '0, m_wready;
    logic [N-1:0]    m_bvalid, m_bready = '0, gnt;
    logic [N*AW-1:0] m_awaddr = '0;
    logic [N*IW-1:0] m_awid = '0;
    logic [N*8-1:0]  m_awlen = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N*SW-1:0] m_wstrb = '0;
    logic [1:0]      m_bresp;
    logic [IW-1:0]   m_bid;
    logic            s_awvalid, s_awready = 1'b0, s_wvalid, s_wlast, s_wready = 1'b0;
    logic            s_bvalid = 1'b0, s_bready;
    logic [AW-1:0]   s_awaddr;
    logic [IW-1:0]   s_awid;
    logic [7:0]      s_awlen;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [1:0]      s_bresp = '0;
    logic [IW-1:0]   s_bid = '0;

    axi_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen),
        .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp),
        .m_bid(m_bid), .m_bready(m_bready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
        .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
        .s_bid(s_bid), .s_bready(s_bready), .gnt(gnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), phase 0=AW 1=W 2=B, last completed master.
    int own = -1;
    int ph = 0;
    int last = N - 1;
    int done_cnt = 0;
    int mph [N];           // master: 0 idle, 1 AW pending, 2 sending W, 3 awaiting B
    logic [AW-1:0] maddr [N];
    logic [IW-1:0] mid [N];
    logic [7:0]    mlen [N];
    int  mbeat [N];
    bit  mwv [N];
    bit  sb_pend = 1'b0;
    int  start_pct = 100, len_max = 0, rdy_pct = 100, mv_pct = 100;
    logic [N-1:0] mask = '1;
    int  obs_q [$];
    logic [N-1:0] gnt_prev = '0;

    function automatic logic [DW-1:0] beat_data(input int i, input int b);
        return maddr[i] ^ (DW'(b) * 32'h0101_0101) ^ (DW'(i) << 28);
    endfunction

    function automatic logic [SW-1:0] beat_strb(input int i, input int b);
        return SW'(b * 3 + i) | SW'(1);
    endfunction

    task automatic model_reset();
        own = -1; ph = 0; last = N - 1; sb_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            mph[i] = 0; mwv[i] = 1'b0; mbeat[i] = 0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (mph[i] == 0 && mask[i] && $urandom_range(0, 99) < start_pct) begin
                mph[i]   = 1;
                maddr[i] = $urandom;
                mid[i]   = IW'($urandom);
                mlen[i]  = 8'($urandom_range(0, len_max));
                mbeat[i] = 0;
                mwv[i]   = 1'b0;
            end
            if ((mph[i] == 1 || mph[i] == 2) && !mwv[i] && $urandom_range(0, 99) < mv_pct)
                mwv[i] = 1'b1;
            m_awvalid[i]           = (mph[i] == 1);
            m_awaddr[i*AW +: AW]   = maddr[i];
            m_awid[i*IW +: IW]     = mid[i];
            m_awlen[i*8 +: 8]      = mlen[i];
            m_wvalid[i]            = mwv[i];
            m_wdata[i*DW +: DW]    = beat_data(i, mbeat[i]);
            m_wstrb[i*SW +: SW]    = beat_strb(i, mbeat[i]);
            m_wlast[i]             = (mbeat[i] == int'(mlen[i]));
            m_bready[i]            = ($urandom_range(0, 99) < mv_pct);
        end
        s_awready = ($urandom_range(0, 99) < rdy_pct);
        s_wready  = ($urandom_range(0, 99) < rdy_pct);
        if (!sb_pend) begin
            // stray responses outside RESP must never reach a master
            s_bvalid = ($urandom_range(0, 9) == 0);
            s_bresp  = 2'($urandom);
            s_bid    = IW'($urandom);
        end else if (!s_bvalid && $urandom_range(0, 99) < rdy_pct) begin
            s_bvalid = 1'b1;
            s_bresp  = 2'($urandom);
            s_bid    = mid[own];
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg, eawr, ewr, ebv;
        logic eav, ewv, ebr;
        int gi;
        eg = '0; eawr = '0; ewr = '0; ebv = '0;
        eav = 1'b0; ewv = 1'b0; ebr = 1'b0;
        if (own >= 0) begin
            eg[own] = 1'b1;
            if (ph == 0) begin
                eav = m_awvalid[own]; eawr[own] = s_awready;
            end else if (ph == 1) begin
                ewv = m_wvalid[own]; ewr[own] = s_wready;
            end else begin
                ebr = m_bready[own]; ebv[own] = s_bvalid;
            end
        end
        check("gnt", 64'(gnt), 64'(eg));
        check("s_valids", 64'({s_awvalid, s_wvalid, s_bready}), 64'({eav, ewv, ebr}));
        check("m_awready", 64'(m_awready), 64'(eawr));
        check("m_wready", 64'(m_wready), 64'(ewr));
        check("m_bvalid", 64'(m_bvalid), 64'(ebv));
        if (eav)
            check("aw_fields", 64'({s_awaddr, s_awid, s_awlen}), 64'({maddr[own], mid[own], mlen[own]}));
        if (ewv)
            check("w_fields", 64'({s_wdata, s_wstrb, s_wlast}),
                  64'({beat_data(own, mbeat[own]), beat_strb(own, mbeat[own]),
                       mbeat[own] == int'(mlen[own])}));
        if (|ebv)
            check("b_fields", 64'({m_bresp, m_bid}), 64'({s_bresp, s_bid}));
        if (gnt_prev == '0 && gnt != '0) begin
            gi = -1;
            for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
            obs_q.push_back(gi);
        end
        gnt_prev = gnt;
    endtask

    task automatic update();
        bit found;
        int idx;
        if (own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (!found && m_awvalid[idx]) begin
                    found = 1'b1; own = idx; ph = 0;
                end
            end
        end else if (ph == 0) begin
            if (m_awvalid[own] && s_awready) begin
                ph = 1; mph[own] = 2;
            end
        end else if (ph == 1) begin
            if (m_wvalid[own] && s_wready) begin
                mwv[own] = 1'b0;
                if (m_wlast[own]) begin
                    ph = 2; mph[own] = 3; sb_pend = 1'b1;
                end else begin
                    mbeat[own]++;
                end
            end
        end else if (s_bvalid && m_bready[own]) begin
            done_cnt++;
            $display("[TB] txn %0d: master %0d addr %h id %0d len %0d bresp %0d",
                     done_cnt, own, maddr[own], mid[own], mlen[own], s_bresp);
            last = own; mph[own] = 0; sb_pend = 1'b0; own = -1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        if (rst) update();
        #1;
        drive();
    endtask

    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    int guard;
    int base;

    initial begin
        model_reset();
        // Reset held with every master requesting: nothing may be granted.
        mask = '1; start_pct = 100; len_max = 0; rdy_pct = 100; mv_pct = 100;
        drive();
        #2;
        check("rst_outputs", 64'({gnt, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}), 64'(0));
        repeat (3) step();
        rst = 1'b1;
        step();
        check("rst_first_gnt", 64'(gnt), 64'(4'b0001));

        // Fairness: everyone requests continuously with single-beat bursts.
        guard = 0;
        while (obs_q.size() < 6 && guard < 200) begin step(); guard++; end
        check("fair_timeout", 64'(guard >= 200), 64'(0));
        for (int k = 0; k < 6 && k < obs_q.size(); k++)
            check($sformatf("fair_order%0d", k), 64'(obs_q[k]), 64'(exp_order[k]));

        // Skip/wrap: drain, let m3 finish, then only m1 and m2 compete.
        mask = '0;
        guard = 0;
        while (!(own < 0 && mph[0] == 0 && mph[1] == 0 && mph[2] == 0 && mph[3] == 0) && guard < 500) begin
            step(); guard++;
        end
        mask = 4'b1000;
        while (!(own == 3 && ph == 2) && guard < 1000) begin step(); guard++; end
        mask = 4'b0110;
        base = obs_q.size();
        while (obs_q.size() < base + 2 && guard < 1500) begin step(); guard++; end
        check("wrap_timeout", 64'(guard >= 1500), 64'(0));
        if (obs_q.size() >= base + 2) begin
            check("wrap_first", 64'(obs_q[base]), 64'(1));
            check("wrap_second", 64'(obs_q[base + 1]), 64'(2));
        end

        // Randomized traffic with a forced heavy-backpressure segment.
        for (int seg = 0; seg < 7; seg++) begin
            mask      = (seg == 0) ? 4'hF : N'($urandom_range(1, 15));
            start_pct = $urandom_range(20, 100);
            len_max   = $urandom_range(0, 7);
            rdy_pct   = (seg == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 50 : 100);
            mv_pct    = $urandom_range(30, 100);
            repeat (300) step();
        end

        // Reset in the middle of a burst, after two beats have been accepted.
        mask = '1; start_pct = 100; len_max = 7; rdy_pct = 60; mv_pct = 80;
        guard = 0;
        while (!(own >= 0 && ph == 1 && mbeat[own] == 2 && mlen[own] >= 3) && guard < 3000) begin
            step(); guard++;
        end
        check("midburst_timeout", 64'(guard >= 3000), 64'(0));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_gnt", 64'(gnt), 64'(0));
        check("rst_async_hs", 64'({m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready}), 64'(0));
        model_reset();
        mask = 4'b0100;
        drive();
        repeat (2) step();
        rst = 1'b1;
        step();
        check("rst2_gnt", 64'(gnt), 64'(4'b0100));

        mask = '1; start_pct = 50; len_max = 4; rdy_pct = 70; mv_pct = 70;
        repeat (200) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
